// File: rtl/harris_pkg.sv
// harris_pkg: shared widths and corner record for the Harris score and corner-picker stages
package harris_pkg;
    localparam int R_W = 64;
    localparam int COORD_W = 8;
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic signed [R_W-1:0] score;
    } corner_t;
endpackage

// File: rtl/harris_corner_fifo.sv
// harris_corner_fifo: first-word-fall-through sync FIFO of corner records with simultaneous push/pop
module harris_corner_fifo
    import harris_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  corner_t din,
    input  logic    pop,
    output corner_t dout,
    output logic    full,
    output logic    empty
);
    localparam int AW = $clog2(DEPTH);
    corner_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic wr, rd;
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign rd = pop && !empty;
    assign wr = push && (!full || rd);
    assign dout = empty ? '0 : mem[rp];
    // pointer and occupancy bookkeeping; a pop frees the slot a same-cycle push into a full FIFO uses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            wp <= wp + AW'(wr);
            rp <= rp + AW'(rd);
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
    // storage needs no reset: only slots between rp and wp are ever presented
    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= din;
    end
endmodule

// File: rtl/harris_corner_picker.sv
// harris_corner_picker: thresholds a raster score stream, applies 3x3 NMS and queues surviving corners
module harris_corner_picker
    import harris_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r_valid,
    input  logic signed [R_W-1:0] r_score,
    input  logic                  frame_start,
    input  logic signed [R_W-1:0] thresh,
    output logic                  corner_valid,
    input  logic                  corner_ready,
    output logic [COORD_W-1:0]    corner_x,
    output logic [COORD_W-1:0]    corner_y,
    output logic signed [R_W-1:0] corner_score,
    output logic                  frame_done,
    output logic                  overflow
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    logic [COORD_W-1:0] x, y, px, py, nx, ny;
    logic [XW-1:0] xi;
    logic signed [R_W-1:0] lb1 [IMG_W];
    logic signed [R_W-1:0] lb2 [IMG_W];
    logic signed [R_W-1:0] t0, t1, m0, m1, b0, b1, n0, n1;
    logic row_end, last, is_corner, push_q, full, empty, pop, drop;
    corner_t push_d, head;
    assign px = frame_start ? '0 : x;
    assign py = frame_start ? '0 : y;
    assign xi = px[XW-1:0];
    assign row_end = px == COORD_W'(IMG_W-1);
    assign last = row_end && py == COORD_W'(IMG_H-1);
    assign n0 = lb2[xi];
    assign n1 = lb1[xi];
    // next raster position and the NMS decision for the centre at (px-1, py-1)
    always_comb begin
        nx = row_end ? '0 : px + COORD_W'(1);
        ny = row_end ? (py == COORD_W'(IMG_H-1) ? '0 : py + COORD_W'(1)) : py;
        is_corner = r_valid && px >= COORD_W'(2) && py >= COORD_W'(2) && m1 > thresh
                    && m1 > t0 && m1 > t1 && m1 > n0 && m1 > m0 && m1 > n1
                    && m1 > b0 && m1 > b1 && m1 > r_score;
    end
    assign pop = corner_valid && corner_ready;
    assign drop = push_q && full && !pop;
    // counters, the two stored window columns, and the registered compare stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
            t0 <= '0;
            t1 <= '0;
            m0 <= '0;
            m1 <= '0;
            b0 <= '0;
            b1 <= '0;
            push_q <= 1'b0;
            push_d <= '0;
            frame_done <= 1'b0;
            overflow <= 1'b0;
        end else begin
            push_q <= is_corner;
            push_d <= '{x: px - COORD_W'(1), y: py - COORD_W'(1), score: m1};
            frame_done <= r_valid && last;
            overflow <= (r_valid && frame_start) ? 1'b0 : (drop ? 1'b1 : overflow);
            if (r_valid) begin
                x <= nx;
                y <= ny;
                t0 <= t1;
                t1 <= n0;
                m0 <= m1;
                m1 <= n1;
                b0 <= b1;
                b1 <= r_score;
            end
        end
    end
    // line buffers hold the two previous rows; stale contents only reach border positions
    always_ff @(posedge clk) begin
        if (r_valid) begin
            lb1[xi] <= r_score;
            lb2[xi] <= lb1[xi];
        end
    end
    harris_corner_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push_q),
        .din(push_d),
        .pop(pop),
        .dout(head),
        .full(full),
        .empty(empty)
    );
    assign corner_valid = !empty;
    assign corner_x = head.x;
    assign corner_y = head.y;
    assign corner_score = head.score;
endmodule

// File: tb/tb_harris_corner_picker.sv
// tb_harris_corner_picker: directed vector table plus hand-written overflow and reset sequences
module tb_harris_corner_picker;
    logic clk = 0;
    logic rst_n = 0;
    logic r_valid = 0;
    logic frame_start = 0;
    logic signed [63:0] r_score = 0;
    logic signed [63:0] thresh = 0;
    logic sel = 0;
    logic rdy8 = 1, rdy16 = 0;
    logic cv8, cv16, fd8, fd16, ov8, ov16;
    logic [7:0] cx8, cy8, cx16, cy16;
    logic signed [63:0] cs8, cs16;
    logic v8, v16;
    assign v8 = r_valid && !sel;
    assign v16 = r_valid && sel;
    always #5 clk = ~clk;

    harris_corner_picker #(.IMG_W(8), .IMG_H(8), .FIFO_DEPTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .r_valid(v8), .r_score(r_score), .frame_start(frame_start),
        .thresh(thresh), .corner_valid(cv8), .corner_ready(rdy8), .corner_x(cx8), .corner_y(cy8),
        .corner_score(cs8), .frame_done(fd8), .overflow(ov8));
    harris_corner_picker #(.IMG_W(16), .IMG_H(16), .FIFO_DEPTH(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .r_valid(v16), .r_score(r_score), .frame_start(frame_start),
        .thresh(thresh), .corner_valid(cv16), .corner_ready(rdy16), .corner_x(cx16), .corner_y(cy16),
        .corner_score(cs16), .frame_done(fd16), .overflow(ov16));

    typedef struct { int x; int y; longint s; } ent_t;
    typedef struct {
        int x0; int y0; longint v0;
        int x1; int y1; longint v1;
        int x2; int y2; longint v2;
        longint th; int en; int ex; int ey; longint es;
    } vec_t;

    int errors = 0, checks = 0;
    int cyc = 0;
    int first_cyc = -1, done_cyc = -1, done_cnt = 0;
    int beat_cyc [256];
    longint img [256];
    ent_t q [$];
    vec_t vecs [9];

    always @(posedge clk) cyc <= cyc + 1;

    // collect popped heads and frame_done pulses of the selected instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (sel ? cv16 : cv8) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (sel ? rdy16 : rdy8)
                    q.push_back('{x: int'(sel ? cx16 : cx8), y: int'(sel ? cy16 : cy8), s: sel ? cs16 : cs8});
            end
            if (sel ? fd16 : fd8) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 0;
    endtask

    task automatic send_frame(input int nb);
        for (int k = 0; k < nb; k++) begin
            @(posedge clk);
            #1;
            r_valid = 1;
            frame_start = (k == 0);
            r_score = img[k];
            beat_cyc[k] = cyc;
        end
        @(posedge clk);
        #1;
        r_valid = 0;
        frame_start = 0;
        r_score = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_mon();
        q.delete();
        first_cyc = -1;
        done_cyc = -1;
        done_cnt = 0;
    endtask

    ent_t e;
    int px16 [10] = '{1, 3, 5, 7, 9, 11, 13, 1, 3, 5};
    int py16 [10] = '{1, 1, 1, 1, 1, 1, 1, 3, 3, 3};

    initial begin
        vecs[0] = '{3, 4, 1000, 0, 0, 0, 0, 0, 0, 100, 1, 3, 4, 1000};
        vecs[1] = '{3, 4, 50, 0, 0, 0, 0, 0, 0, 100, 0, 0, 0, 0};
        vecs[2] = '{2, 2, 500, 3, 2, 500, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[3] = '{2, 2, 500, 3, 2, 499, 0, 0, 0, 0, 1, 2, 2, 500};
        vecs[4] = '{0, 5, 900, 7, 7, 900, 4, 0, 900, 0, 0, 0, 0, 0};
        vecs[5] = '{3, 4, 100, 0, 0, 0, 0, 0, 0, 100, 0, 0, 0, 0};
        vecs[6] = '{4, 4, -10, 0, 0, 0, 0, 0, 0, -20, 0, 0, 0, 0};
        vecs[7] = '{6, 6, 7, 0, 0, 0, 0, 0, 0, -1, 1, 6, 6, 7};
        vecs[8] = '{5, 1, 3, 0, 0, 0, 0, 0, 0, -5, 1, 5, 1, 3};

        #12;
        chk("reset corner_valid", cv8, 0);
        chk("reset frame_done", fd8, 0);
        chk("reset overflow", ov8, 0);
        chk("reset corner_score", cs8, 0);
        chk("reset corner_valid16", cv16, 0);
        rst_n = 1;
        idle(2);

        for (int i = 0; i < 9; i++) begin
            clear_img();
            img[vecs[i].y0*8 + vecs[i].x0] = vecs[i].v0;
            img[vecs[i].y1*8 + vecs[i].x1] = vecs[i].v1;
            img[vecs[i].y2*8 + vecs[i].x2] = vecs[i].v2;
            thresh = vecs[i].th;
            reset_mon();
            send_frame(64);
            idle(5);
            chk($sformatf("v%0d count", i), q.size(), vecs[i].en);
            chk($sformatf("v%0d done_cnt", i), done_cnt, 1);
            chk($sformatf("v%0d done_cyc", i), done_cyc, beat_cyc[63] + 1);
            chk($sformatf("v%0d overflow", i), ov8, 0);
            if (q.size() == 1 && vecs[i].en == 1) begin
                chk($sformatf("v%0d x", i), q[0].x, vecs[i].ex);
                chk($sformatf("v%0d y", i), q[0].y, vecs[i].ey);
                chk($sformatf("v%0d score", i), q[0].s, vecs[i].es);
                chk($sformatf("v%0d latency", i), first_cyc, beat_cyc[(vecs[i].ey+1)*8 + vecs[i].ex + 1] + 2);
            end
        end

        sel = 1;
        rdy16 = 0;
        clear_img();
        for (int i = 0; i < 10; i++) img[py16[i]*16 + px16[i]] = 100 + i;
        thresh = 0;
        reset_mon();
        send_frame(256);
        idle(3);
        chk("ovf overflow", ov16, 1);
        chk("ovf valid", cv16, 1);
        chk("ovf head x", cx16, 1);
        idle(3);
        chk("ovf hold x", cx16, 1);
        chk("ovf hold y", cy16, 1);
        chk("ovf hold score", cs16, 100);
        rdy16 = 1;
        idle(12);
        chk("ovf drained", q.size(), 8);
        chk("ovf empty", cv16, 0);
        for (int i = 0; i < 8; i++) begin
            e = (i < q.size()) ? q[i] : '{x: -1, y: -1, s: -1};
            chk($sformatf("ovf%0d x", i), e.x, px16[i]);
            chk($sformatf("ovf%0d y", i), e.y, py16[i]);
            chk($sformatf("ovf%0d score", i), e.s, 100 + i);
        end
        clear_img();
        send_frame(1);
        idle(1);
        chk("ovf cleared by frame_start", ov16, 0);

        sel = 0;
        rdy8 = 0;
        clear_img();
        img[4*8 + 3] = 1000;
        thresh = 100;
        reset_mon();
        send_frame(64);
        idle(3);
        chk("rst held valid", cv8, 1);
        send_frame(20);
        #1;
        rst_n = 0;
        #1;
        chk("rst async valid", cv8, 0);
        chk("rst async x", cx8, 0);
        chk("rst async y", cy8, 0);
        chk("rst async score", cs8, 0);
        chk("rst async done", fd8, 0);
        chk("rst async overflow", ov8, 0);
        rdy8 = 1;
        idle(2);
        rst_n = 1;
        idle(2);
        reset_mon();
        send_frame(64);
        idle(5);
        chk("post-rst count", q.size(), 1);
        if (q.size() == 1) begin
            chk("post-rst x", q[0].x, 3);
            chk("post-rst y", q[0].y, 4);
            chk("post-rst score", q[0].s, 1000);
        end
        chk("post-rst done", done_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
